// File: rtl/yarp_fetch_if.sv
// Signal bundle for the YARP fetch stage: execute redirect, instruction-memory
// request/response bus and the decode-side valid/ready handshake.
interface yarp_fetch_if;
  logic        redirect_i;
  logic [31:0] redirect_pc_i;
  logic        imem_req_o;
  logic [31:0] imem_addr_o;
  logic        imem_gnt_i;
  logic        imem_rvalid_i;
  logic [31:0] imem_rdata_i;
  logic        instr_valid_o;
  logic [31:0] instr_o;
  logic [31:0] pc_o;
  logic        instr_ready_i;

  modport master (
    input  redirect_i, redirect_pc_i, imem_gnt_i, imem_rvalid_i, imem_rdata_i, instr_ready_i,
    output imem_req_o, imem_addr_o, instr_valid_o, instr_o, pc_o
  );

  modport slave (
    output redirect_i, redirect_pc_i, imem_gnt_i, imem_rvalid_i, imem_rdata_i, instr_ready_i,
    input  imem_req_o, imem_addr_o, instr_valid_o, instr_o, pc_o
  );
endinterface

// File: rtl/yarp_fetch.sv
// YARP fetch stage: PC generation, credit-limited instruction memory reads,
// a small {pc, instr} buffer toward decode, and redirect flush/drain.
module yarp_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned DEPTH    = 2
) (
  input  logic         clk,
  input  logic         reset,
  yarp_fetch_if.master bus
);

  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = $clog2(DEPTH + 1);
  localparam logic [CW-1:0] DEPTH_CNT = CW'(DEPTH);
  localparam logic [CW:0]   DEPTH_SUM = (CW+1)'(DEPTH);

  typedef enum logic {FETCH, DRAIN} state_t;

  state_t        state;
  state_t        state_next;

  logic [31:0]   fetch_pc;
  logic [31:0]   resp_pc;
  logic [31:0]   pc_mem    [DEPTH];
  logic [31:0]   instr_mem [DEPTH];
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_ptr;
  logic [CW-1:0] count;
  logic [CW-1:0] outstanding;
  logic [CW-1:0] discard;

  logic          head_valid;
  logic          pop;
  logic          push;
  logic          issue;
  logic          req;
  logic [31:0]   instr_head;
  logic [31:0]   pc_head;
  logic [CW:0]   credit_used;
  logic [31:0]   redirect_target;
  logic [CW-1:0] discard_on_redirect;

  assign redirect_target     = {bus.redirect_pc_i[31:2], 2'b00};
  // Every request still in flight at redirect time is stale, except one answered this very cycle.
  assign discard_on_redirect = outstanding - CW'(bus.imem_rvalid_i);

  assign head_valid  = !reset && (count != '0) && !bus.redirect_i;
  assign pop         = head_valid && bus.instr_ready_i;
  assign credit_used = {1'b0, count} + {1'b0, outstanding} - (CW+1)'(pop);
  assign issue       = req && bus.imem_gnt_i;
  assign push        = !reset && (state == FETCH) && !bus.redirect_i && bus.imem_rvalid_i;

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= FETCH;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    if (bus.redirect_i) begin
      state_next = (discard_on_redirect != '0) ? DRAIN : FETCH;
    end else if ((state == DRAIN) && bus.imem_rvalid_i && (discard == CW'(1))) begin
      state_next = FETCH;
    end
  end

  always_comb begin
    req        = 1'b0;
    instr_head = '0;
    pc_head    = '0;
    if (!reset) begin
      req        = (state == FETCH) && !bus.redirect_i && (credit_used < DEPTH_SUM);
      instr_head = instr_mem[rd_ptr];
      pc_head    = pc_mem[rd_ptr];
    end
  end

  assign bus.imem_req_o    = req;
  assign bus.imem_addr_o   = fetch_pc;
  assign bus.instr_valid_o = head_valid;
  assign bus.instr_o       = instr_head;
  assign bus.pc_o          = pc_head;

  always_ff @(posedge clk) begin
    if (reset) begin
      fetch_pc    <= RESET_PC;
      resp_pc     <= RESET_PC;
      rd_ptr      <= '0;
      wr_ptr      <= '0;
      count       <= '0;
      outstanding <= '0;
      discard     <= '0;
      for (int i = 0; i < int'(DEPTH); i++) begin
        pc_mem[i]    <= '0;
        instr_mem[i] <= '0;
      end
    end else begin
      outstanding <= outstanding + CW'(issue) - CW'(bus.imem_rvalid_i);
      if (bus.redirect_i) begin
        fetch_pc <= redirect_target;
        resp_pc  <= redirect_target;
        rd_ptr   <= '0;
        wr_ptr   <= '0;
        count    <= '0;
        discard  <= discard_on_redirect;
      end else begin
        if (issue) begin
          fetch_pc <= fetch_pc + 32'd4;
        end
        if (push) begin
          pc_mem[wr_ptr]    <= resp_pc;
          instr_mem[wr_ptr] <= bus.imem_rdata_i;
          wr_ptr            <= wr_ptr + PW'(1);
          resp_pc           <= resp_pc + 32'd4;
        end
        if (pop) begin
          rd_ptr <= rd_ptr + PW'(1);
        end
        count <= count + CW'(push) - CW'(pop);
        if ((state == DRAIN) && bus.imem_rvalid_i) begin
          discard <= discard - CW'(1);
        end
      end
    end
  end

  // The credit check on requests makes a push into a full, non-draining buffer impossible.
  a_no_overflow: assert property (@(posedge clk) disable iff (reset)
    !(push && !pop && (count == DEPTH_CNT)));

  a_no_orphan_resp: assert property (@(posedge clk) disable iff (reset)
    !(bus.imem_rvalid_i && (outstanding == '0)));

endmodule

// File: tb/tb_yarp_fetch.sv
// Self-checking bench for yarp_fetch: directed scenarios plus a randomized run,
// all checked against a queue-based model of issued requests and buffered words.
module tb_yarp_fetch;
  localparam logic [31:0] RESET_PC = 32'h0000_0100;
  localparam int          DEPTH    = 2;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] pc;
    int          epoch;
    int          due;
  } pend_t;

  logic clk   = 1'b0;
  logic reset = 1'b1;

  yarp_fetch_if bus ();

  yarp_fetch #(.RESET_PC(RESET_PC), .DEPTH(DEPTH)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  pend_t       mem_q[$];
  logic [31:0] buf_q[$];
  logic [31:0] exp_fetch;
  int          epoch;
  int          cyc;
  int          last_due;
  int          lat_min;
  int          lat_max;
  int          n_cmp;
  int          n_err;
  logic [97:0] obs_v;
  logic [97:0] exp_v;
  logic        obs_req;
  logic        obs_valid;
  logic        obs_deliv;
  logic [31:0] obs_addr;
  logic [31:0] obs_pc;
  logic [65:0] rst_obs [2];

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_C3C3;
  endfunction

  task automatic do_reset();
    reset              = 1'b1;
    bus.redirect_i     = 1'b0;
    bus.redirect_pc_i  = 32'h0;
    bus.imem_gnt_i     = 1'b0;
    bus.imem_rvalid_i  = 1'b0;
    bus.imem_rdata_i   = 32'h0;
    bus.instr_ready_i  = 1'b0;
    for (int i = 0; i < 2; i++) begin
      #1;
      rst_obs[i] = {bus.imem_req_o, bus.instr_valid_o, bus.instr_o, bus.pc_o};
      @(posedge clk);
      @(negedge clk);
    end
    reset = 1'b0;
    mem_q.delete();
    buf_q.delete();
    exp_fetch = RESET_PC;
    epoch     = 0;
    cyc       = 1;
    last_due  = 0;
  endtask

  // One clock cycle: drive inputs, sample DUT, form expectations, then advance the model.
  task automatic step(input bit gnt, input bit ready, input bit redir, input logic [31:0] rpc);
    pend_t       e;
    bit          stale;
    bit          exp_req;
    bit          exp_valid;
    bit          pop;
    logic [31:0] head;
    int          used;
    int          due;
    bus.imem_gnt_i    = gnt;
    bus.instr_ready_i = ready;
    bus.redirect_i    = redir;
    bus.redirect_pc_i = rpc;
    if (mem_q.size() != 0 && mem_q[0].due <= cyc) begin
      bus.imem_rvalid_i = 1'b1;
      bus.imem_rdata_i  = mem_word(mem_q[0].addr);
    end else begin
      bus.imem_rvalid_i = 1'b0;
      bus.imem_rdata_i  = $urandom;
    end
    #1;
    stale = 1'b0;
    foreach (mem_q[i]) if (mem_q[i].epoch != epoch) stale = 1'b1;
    head      = (buf_q.size() != 0) ? buf_q[0] : 32'h0;
    exp_valid = (buf_q.size() != 0) && !redir;
    pop       = exp_valid && ready;
    used      = buf_q.size() + mem_q.size() - (pop ? 1 : 0);
    exp_req   = !redir && !stale && (used < DEPTH);
    exp_v = {exp_req, exp_req ? exp_fetch : 32'h0, exp_valid,
             exp_valid ? head : 32'h0, exp_valid ? mem_word(head) : 32'h0};
    obs_req   = bus.imem_req_o;
    obs_addr  = bus.imem_addr_o;
    obs_valid = bus.instr_valid_o;
    obs_pc    = bus.pc_o;
    obs_deliv = obs_valid && ready;
    obs_v = {obs_req, exp_req ? obs_addr : 32'h0, obs_valid,
             exp_valid ? obs_pc : 32'h0, exp_valid ? bus.instr_o : 32'h0};
    if (pop) void'(buf_q.pop_front());
    if (bus.imem_rvalid_i) begin
      e = mem_q.pop_front();
      if (!redir && e.epoch == epoch) buf_q.push_back(e.pc);
    end
    if (obs_req && gnt) begin
      due = cyc + int'($urandom_range(lat_max, lat_min));
      if (due <= last_due) due = last_due + 1;
      last_due = due;
      e.addr   = obs_addr;
      e.pc     = exp_fetch;
      e.epoch  = epoch;
      e.due    = due;
      mem_q.push_back(e);
      exp_fetch = exp_fetch + 32'd4;
    end
    if (redir) begin
      buf_q.delete();
      epoch++;
      exp_fetch = {rpc[31:2], 2'b00};
    end
    @(posedge clk);
    cyc++;
    @(negedge clk);
  endtask

  task automatic test_reset();
    do_reset();
    for (int i = 0; i < 2; i++) begin
      n_cmp++;
      if (rst_obs[i] !== 66'h0) begin
        n_err++;
        $display("[TB] FAIL reset_outputs[%0d]: got %h want 0", i, rst_obs[i]);
      end
    end
    step(1'b1, 1'b1, 1'b0, 32'h0);
    n_cmp++;
    if ({obs_req, obs_addr} !== {1'b1, RESET_PC}) begin
      n_err++;
      $display("[TB] FAIL first_fetch: got req %0b addr %h want req 1 addr %h", obs_req, obs_addr, RESET_PC);
    end
    for (int i = 0; i < 6; i++) begin
      step(1'b1, 1'b1, 1'b0, 32'h0);
      n_cmp++;
      if (obs_v !== exp_v) begin
        n_err++;
        $display("[TB] FAIL reset_run cyc %0d: got %h want %h", cyc - 1, obs_v, exp_v);
      end
    end
    do_reset();
    for (int i = 0; i < 2; i++) begin
      n_cmp++;
      if (rst_obs[i] !== 66'h0) begin
        n_err++;
        $display("[TB] FAIL midop_reset[%0d]: got %h want 0", i, rst_obs[i]);
      end
    end
    step(1'b1, 1'b1, 1'b0, 32'h0);
    n_cmp++;
    if ({obs_req, obs_addr} !== {1'b1, RESET_PC}) begin
      n_err++;
      $display("[TB] FAIL refetch_after_reset: got req %0b addr %h want req 1 addr %h", obs_req, obs_addr, RESET_PC);
    end
  endtask

  task automatic test_stream();
    int first_valid;
    int n_deliv;
    do_reset();
    lat_min = 1; lat_max = 1;
    first_valid = -1;
    n_deliv = 0;
    for (int i = 0; i < 12; i++) begin
      step(1'b1, 1'b1, 1'b0, 32'h0);
      if (obs_deliv) begin
        n_deliv++;
        if (first_valid < 0) first_valid = cyc - 1;
      end
      n_cmp++;
      if (obs_v !== exp_v) begin
        n_err++;
        $display("[TB] FAIL stream cyc %0d: got %h want %h", cyc - 1, obs_v, exp_v);
      end
    end
    n_cmp++;
    if (first_valid !== 3) begin
      n_err++;
      $display("[TB] FAIL stream_first_valid: got cycle %0d want 3", first_valid);
    end
    n_cmp++;
    if (n_deliv !== 10) begin
      n_err++;
      $display("[TB] FAIL stream_throughput: got %0d deliveries want 10", n_deliv);
    end
  endtask

  task automatic test_stall();
    int grants;
    do_reset();
    lat_min = 1; lat_max = 1;
    grants = 0;
    for (int i = 0; i < 8; i++) begin
      step(1'b1, 1'b0, 1'b0, 32'h0);
      if (obs_req) grants++;
      n_cmp++;
      if (obs_v !== exp_v) begin
        n_err++;
        $display("[TB] FAIL stall cyc %0d: got %h want %h", cyc - 1, obs_v, exp_v);
      end
    end
    n_cmp++;
    if (grants !== DEPTH) begin
      n_err++;
      $display("[TB] FAIL stall_grants: got %0d want %0d", grants, DEPTH);
    end
    n_cmp++;
    if ({obs_valid, obs_pc} !== {1'b1, RESET_PC}) begin
      n_err++;
      $display("[TB] FAIL stall_head: got valid %0b pc %h want valid 1 pc %h", obs_valid, obs_pc, RESET_PC);
    end
    for (int i = 0; i < 12; i++) begin
      step(1'b1, 1'b1, 1'b0, 32'h0);
      n_cmp++;
      if (obs_v !== exp_v) begin
        n_err++;
        $display("[TB] FAIL stall_release cyc %0d: got %h want %h", cyc - 1, obs_v, exp_v);
      end
    end
  endtask

  task automatic test_redirect_drain();
    int          first_req;
    logic [31:0] first_pc;
    bit          got_pc;
    do_reset();
    lat_min = 3; lat_max = 3;
    first_req = -1;
    first_pc  = 32'h0;
    got_pc    = 1'b0;
    for (int i = 0; i < 15; i++) begin
      step(1'b1, 1'b1, (i == 2), 32'h0000_0200);
      if (i > 2 && obs_req && first_req < 0) first_req = cyc - 1;
      if (i > 2 && obs_deliv && !got_pc) begin
        first_pc = obs_pc;
        got_pc   = 1'b1;
      end
      n_cmp++;
      if (obs_v !== exp_v) begin
        n_err++;
        $display("[TB] FAIL drain cyc %0d: got %h want %h", cyc - 1, obs_v, exp_v);
      end
    end
    n_cmp++;
    if (first_req !== 6) begin
      n_err++;
      $display("[TB] FAIL drain_first_req: got cycle %0d want 6", first_req);
    end
    n_cmp++;
    if ({got_pc, first_pc} !== {1'b1, 32'h0000_0200}) begin
      n_err++;
      $display("[TB] FAIL drain_first_pc: got seen %0b pc %h want pc 00000200", got_pc, first_pc);
    end
  endtask

  task automatic test_redirect_rvalid();
    logic [31:0] first_pc;
    bit          got_pc;
    do_reset();
    lat_min = 1; lat_max = 1;
    first_pc = 32'h0;
    got_pc   = 1'b0;
    for (int i = 0; i < 9; i++) begin
      step(1'b1, 1'b1, (i == 1), 32'h0000_0203);
      if (i == 2) begin
        n_cmp++;
        if ({obs_req, obs_addr} !== {1'b1, 32'h0000_0200}) begin
          n_err++;
          $display("[TB] FAIL rvalid_redirect_req: got req %0b addr %h want req 1 addr 00000200", obs_req, obs_addr);
        end
      end
      if (i > 1 && obs_deliv && !got_pc) begin
        first_pc = obs_pc;
        got_pc   = 1'b1;
      end
      n_cmp++;
      if (obs_v !== exp_v) begin
        n_err++;
        $display("[TB] FAIL rvalid_redirect cyc %0d: got %h want %h", cyc - 1, obs_v, exp_v);
      end
    end
    n_cmp++;
    if ({got_pc, first_pc} !== {1'b1, 32'h0000_0200}) begin
      n_err++;
      $display("[TB] FAIL rvalid_redirect_pc: got seen %0b pc %h want pc 00000200", got_pc, first_pc);
    end
  endtask

  task automatic test_wrap();
    logic [31:0] pcs[$];
    do_reset();
    lat_min = 1; lat_max = 1;
    for (int i = 0; i < 10; i++) begin
      step(1'b1, 1'b1, (i == 0), 32'hFFFF_FFFC);
      if (obs_deliv) pcs.push_back(obs_pc);
      n_cmp++;
      if (obs_v !== exp_v) begin
        n_err++;
        $display("[TB] FAIL wrap cyc %0d: got %h want %h", cyc - 1, obs_v, exp_v);
      end
    end
    while (pcs.size() < 2) pcs.push_back(32'hDEAD_BEEF);
    n_cmp++;
    if ({pcs[0], pcs[1]} !== {32'hFFFF_FFFC, 32'h0000_0000}) begin
      n_err++;
      $display("[TB] FAIL wrap_pcs: got %h %h want fffffffc 00000000", pcs[0], pcs[1]);
    end
  endtask

  task automatic test_random();
    int          n_deliv;
    bit          redir;
    logic [31:0] rpc;
    do_reset();
    lat_min = 1; lat_max = 3;
    n_deliv = 0;
    for (int i = 0; i < 3000; i++) begin
      redir = ($urandom_range(19, 0) == 0);
      rpc   = ($urandom_range(3, 0) == 0) ? (32'hFFFF_FFF0 | ($urandom & 32'hF)) : $urandom;
      step(1'($urandom_range(1, 0)), ($urandom_range(3, 0) != 0), redir, rpc);
      if (obs_deliv) n_deliv++;
      n_cmp++;
      if (obs_v !== exp_v) begin
        n_err++;
        $display("[TB] FAIL random cyc %0d: got %h want %h", cyc - 1, obs_v, exp_v);
      end
    end
    n_cmp++;
    if (n_deliv < 300) begin
      n_err++;
      $display("[TB] FAIL random_progress: got %0d deliveries want at least 300", n_deliv);
    end
  endtask

  initial begin
    n_cmp   = 0;
    n_err   = 0;
    lat_min = 1;
    lat_max = 1;
    bus.redirect_i    = 1'b0;
    bus.redirect_pc_i = 32'h0;
    bus.imem_gnt_i    = 1'b0;
    bus.imem_rvalid_i = 1'b0;
    bus.imem_rdata_i  = 32'h0;
    bus.instr_ready_i = 1'b0;
    @(negedge clk);
    $display("[TB] starting yarp_fetch bench");
    test_reset();
    test_stream();
    test_stall();
    test_redirect_drain();
    test_redirect_rvalid();
    test_wrap();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
